// File: rtl/my_ram8_pkg.sv
// Shared sizing, types and the clear-engine state encoding for the RAM hierarchy.
package my_ram_pkg;

    localparam int WORD_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam addr_t LAST_ADDR = 3'd7;
    localparam word_t ZERO_WORD = 16'h0000;

endpackage

// File: rtl/my_ram8_dmux8way.sv
// 1-to-8 demultiplexer: routes a single enable bit to the output selected by sel.
module my_dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);

    // Decode sel into a one-hot copy of the input bit.
    always_comb begin
        a = 1'b0;
        b = 1'b0;
        c = 1'b0;
        d = 1'b0;
        e = 1'b0;
        f = 1'b0;
        g = 1'b0;
        h = 1'b0;
        case (sel)
            3'd0:    a = in;
            3'd1:    b = in;
            3'd2:    c = in;
            3'd3:    d = in;
            3'd4:    e = in;
            3'd5:    f = in;
            3'd6:    g = in;
            3'd7:    h = in;
            default: a = 1'b0;
        endcase
    end

endmodule

// File: rtl/my_ram8.sv
// Eight-word 16-bit register bank with combinational read and a sequential
// clear engine that zeroes one word per cycle while busy is high.
module my_ram8
    import my_ram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              clr,
    output logic [WORD_W-1:0] out,
    output logic              busy
);

    state_t           r_state;
    state_t           w_next_state;
    addr_t            r_ptr;
    addr_t            w_next_ptr;
    word_t            r_word [DEPTH];
    logic             w_busy;
    logic             w_we;
    addr_t            w_wa;
    word_t            w_wdata;
    logic [DEPTH-1:0] w_en;

    assign w_busy = (r_state == CLEAR);
    assign busy   = w_busy;

    // While sweeping, the pointer owns the write port and user loads are dropped.
    assign w_we    = (load & ~w_busy) | w_busy;
    assign w_wa    = w_busy ? r_ptr : address;
    assign w_wdata = w_busy ? ZERO_WORD : in;

    my_dmux8way u_dmux (
        .in  (w_we),
        .sel (w_wa),
        .a   (w_en[0]),
        .b   (w_en[1]),
        .c   (w_en[2]),
        .d   (w_en[3]),
        .e   (w_en[4]),
        .f   (w_en[5]),
        .g   (w_en[6]),
        .h   (w_en[7])
    );

    // Word storage: each word loads when its decoded enable is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_word[i] <= ZERO_WORD;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_en[i]) begin
                    r_word[i] <= w_wdata;
                end else begin
                    r_word[i] <= r_word[i];
                end
            end
        end
    end

    // Clear-engine state and pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    // Clear-engine next state: the exit edge wraps ptr back to 0 for free.
    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        case (r_state)
            IDLE: begin
                if (clr) begin
                    w_next_state = CLEAR;
                    w_next_ptr   = 3'd0;
                end else begin
                    w_next_state = IDLE;
                    w_next_ptr   = r_ptr;
                end
            end
            CLEAR: begin
                w_next_ptr = r_ptr + 3'd1;
                if (r_ptr == LAST_ADDR) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = CLEAR;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_ptr   = 3'd0;
            end
        endcase
    end

    // 8:1 read selector keyed by address.
    always_comb begin
        out = ZERO_WORD;
        case (address)
            3'd0:    out = r_word[0];
            3'd1:    out = r_word[1];
            3'd2:    out = r_word[2];
            3'd3:    out = r_word[3];
            3'd4:    out = r_word[4];
            3'd5:    out = r_word[5];
            3'd6:    out = r_word[6];
            3'd7:    out = r_word[7];
            default: out = ZERO_WORD;
        endcase
    end

endmodule

// File: tb/tb_my_ram8.sv
// Self-checking bench for my_ram8: vector table, directed clear-engine
// sequences and randomized traffic against a behavioural word-array model.
module tb_my_ram8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] t_in;
    logic        load;
    logic [2:0]  address;
    logic        clr;
    logic [15:0] out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain word array plus number of words still to sweep.
    logic [15:0] mem_m [8];
    int          sweep_left = 0;

    typedef struct {
        logic        rst;
        logic        ld;
        logic        cl;
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] eo;
        logic        eb;
    } vec_t;

    vec_t vt [17];

    my_ram8 dut (
        .clk     (clk),
        .reset   (reset),
        .in      (t_in),
        .load    (load),
        .address (address),
        .clr     (clr),
        .out     (out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic c,
                         input logic [2:0] a, input logic [15:0] d);
        reset   = r;
        load    = l;
        clr     = c;
        address = a;
        t_in    = d;
    endtask

    // Advance one rising edge, update the model from the sampled inputs, settle.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 8; i++) mem_m[i] = 16'h0000;
            sweep_left = 0;
        end else if (sweep_left > 0) begin
            mem_m[8 - sweep_left] = 16'h0000;
            sweep_left--;
        end else begin
            if (load) mem_m[address] = t_in;
            if (clr) sweep_left = 8;
        end
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'(i), 16'(16'hA5A0 + i));
            tick();
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, 3'(i), 16'h0000);
            #1;
            check(name, out, 16'h0000);
        end
    endtask

    initial begin
        int cnt;

        vt[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 3'd3, 16'h1234, 16'h1234, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 3'd7, 16'hBEEF, 16'hBEEF, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 3'd3, 16'h0000, 16'h1234, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 3'd2, 16'h0000, 16'h0000, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 3'd4, 16'h0000, 16'h0000, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 3'd5, 16'h0000, 16'h0000, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 3'd6, 16'h0000, 16'h0000, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 3'd7, 16'h0000, 16'hBEEF, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 3'd5, 16'h0001, 16'h0001, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 3'd5, 16'h0002, 16'h0002, 1'b0};
        vt[13] = '{1'b0, 1'b1, 1'b0, 3'd5, 16'h0003, 16'h0003, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 3'd3, 16'h0000, 16'h1234, 1'b0};
        vt[15] = '{1'b0, 1'b0, 1'b0, 3'd7, 16'h0000, 16'hBEEF, 1'b0};
        vt[16] = '{1'b0, 1'b0, 1'b0, 3'd4, 16'h0000, 16'h0000, 1'b0};

        drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        tick();
        tick();
        check("reset_out", out, 16'h0000);
        check("reset_busy", 16'(busy), 16'h0000);

        for (int k = 0; k < 17; k++) begin
            drive(vt[k].rst, vt[k].ld, vt[k].cl, vt[k].a, vt[k].d);
            tick();
            check($sformatf("vec%0d_out", k), out, vt[k].eo);
            check($sformatf("vec%0d_busy", k), 16'(busy), 16'(vt[k].eb));
        end

        // No write-through: new data must not appear before the edge.
        drive(1'b0, 1'b1, 1'b0, 3'd5, 16'h0044);
        #1;
        check("no_write_through", out, 16'h0003);
        tick();
        check("write_after_edge", out, 16'h0044);

        // Sweep progression: word j clears on the (j+1)th edge after busy rises.
        fill();
        drive(1'b0, 1'b0, 1'b1, 3'd0, 16'h0000);
        tick();
        check("sweep_busy_rise", 16'(busy), 16'h0001);
        for (int j = 0; j < 8; j++) begin
            drive(1'b0, 1'b0, 1'b0, 3'(j), 16'h0000);
            #1;
            check($sformatf("sweep_pre%0d", j), out, 16'(16'hA5A0 + j));
            tick();
            check($sformatf("sweep_post%0d", j), out, 16'h0000);
            check($sformatf("sweep_busy%0d", j), 16'(busy), 16'(j != 7));
        end

        // Load and clr during busy are both ignored.
        fill();
        drive(1'b0, 1'b0, 1'b1, 3'd0, 16'h0000);
        tick();
        cnt = busy ? 1 : 0;
        for (int i = 0; i < 20 && busy; i++) begin
            drive(1'b0, i == 4, i == 2, (i == 4) ? 3'd2 : 3'd0, 16'hFFFF);
            tick();
            if (busy) cnt++;
        end
        check("busy_cycles", 16'(cnt), 16'd8);
        check_all_zero("ignored_during_busy");

        // Same-edge clr+load in IDLE: write lands, then gets swept.
        drive(1'b0, 1'b1, 1'b1, 3'd4, 16'h7777);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd4, 16'h0000);
        #1;
        check("clr_load_write", out, 16'h7777);
        check("clr_load_busy", 16'(busy), 16'h0001);
        for (int i = 0; i < 20 && busy; i++) tick();
        check("clr_load_done", 16'(busy), 16'h0000);
        check("clr_load_swept", out, 16'h0000);

        // Reset in the 4th cycle of a sweep.
        fill();
        drive(1'b0, 1'b0, 1'b1, 3'd0, 16'h0000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b0, 3'd6, 16'h0000);
        tick();
        check("midsweep_reset_busy", 16'(busy), 16'h0000);
        check_all_zero("midsweep_reset_zero");
        drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h0042);
        tick();
        check("post_reset_write", out, 16'h0042);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(63) == 0), $urandom_range(1) == 1,
                  ($urandom_range(15) == 0), 3'($urandom_range(7)), 16'($urandom));
            tick();
            check("rand_busy", 16'(busy), 16'(sweep_left > 0));
            check("rand_out", out, mem_m[address]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
